// File: rtl/ddram_burst_responder.sv
// Slave end of the 64-bit DDRAM burst bus: splits read/write bursts into single-beat
// accesses on an in-order pipelined MEM port and returns read beats in address order.
module ddram_burst_responder #(
  parameter int ADDRBITS        = 24,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDRBITS:0] DDRAM_ADDR,
  input  logic [63:0]       DDRAM_DIN,
  input  logic [7:0]        DDRAM_BE,
  input  logic [7:0]        DDRAM_BURSTCNT,
  input  logic              DDRAM_RD,
  input  logic              DDRAM_WE,
  output logic              DDRAM_BUSY,
  output logic [63:0]       DDRAM_DOUT,
  output logic              DDRAM_DOUT_READY,
  output logic [ADDRBITS:0] MEM_ADDR,
  output logic              MEM_RD,
  output logic              MEM_WE,
  output logic [63:0]       MEM_DIN,
  output logic [7:0]        MEM_BE,
  input  logic              MEM_WAIT,
  input  logic [63:0]       MEM_DOUT,
  input  logic              MEM_DOUT_VALID,
  output logic              PROTO_ERR
);
  localparam int AW  = ADDRBITS + 1;
  localparam int DRW = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [7:0]     MAX_OUT    = 8'(MAX_OUTSTANDING);
  localparam logic [DRW-1:0] DRAIN_INIT = DRW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;
  state_t r_state, w_next;

  logic [AW-1:0]  r_start, r_waddr;
  logic [7:0]     r_n, r_issued, r_recvd, r_beats_left;
  logic           r_wbuf_full;
  logic [63:0]    r_wdata;
  logic [7:0]     r_wbe;
  logic [63:0]    r_dout;
  logic           r_dout_ready, r_proto_err;
  logic [DRW-1:0] r_drain;

  logic [7:0] w_n, w_outstanding;
  logic       w_rd_acc, w_we_acc_idle, w_wr_wait, w_we_acc_wr, w_rd_abort;
  logic       w_rd_take, w_wr_take, w_ret, w_last;

  assign w_n           = (DDRAM_BURSTCNT == 8'd0) ? 8'd1 : DDRAM_BURSTCNT;
  assign w_outstanding = r_issued - r_recvd;
  assign w_rd_acc      = (r_state == S_IDLE) && DDRAM_RD;
  assign w_we_acc_idle = (r_state == S_IDLE) && DDRAM_WE && !DDRAM_RD;
  // Write buffer drained but burst incomplete: bus is open for the next WE beat only
  assign w_wr_wait     = (r_state == S_WR) && !r_wbuf_full && (r_beats_left != 8'd0);
  assign w_we_acc_wr   = w_wr_wait && DDRAM_WE && !DDRAM_RD;
  assign w_rd_abort    = w_wr_wait && DDRAM_RD;
  assign w_rd_take     = MEM_RD && !MEM_WAIT;
  assign w_wr_take     = MEM_WE && !MEM_WAIT;
  assign w_ret         = (r_state == S_RD) && MEM_DOUT_VALID;
  assign w_last        = w_ret && ((r_recvd + 8'd1) == r_n);

  assign DDRAM_DOUT       = r_dout;
  assign DDRAM_DOUT_READY = r_dout_ready;
  assign MEM_DIN          = r_wdata;
  assign MEM_BE           = r_wbe;
  assign PROTO_ERR        = r_proto_err;

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (DDRAM_RD)      w_next = S_RD;
        else if (DDRAM_WE) w_next = S_WR;
      end
      S_RD: if (w_last) w_next = S_IDLE;
      S_WR: begin
        if (w_rd_abort || (r_beats_left == 8'd0 && (!r_wbuf_full || w_wr_take)))
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Strobes are gated by RESET so an abort stops MEM traffic in the reset cycle itself
  always_comb begin
    DDRAM_BUSY = RESET;
    MEM_RD     = 1'b0;
    MEM_WE     = 1'b0;
    MEM_ADDR   = '0;
    case (r_state)
      S_RD: begin
        DDRAM_BUSY = 1'b1;
        MEM_RD     = !RESET && (r_issued < r_n) && (w_outstanding < MAX_OUT);
        MEM_ADDR   = r_start + AW'(r_issued);
      end
      S_WR: begin
        if (r_wbuf_full) DDRAM_BUSY = 1'b1;
        MEM_WE   = !RESET && r_wbuf_full;
        MEM_ADDR = r_waddr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_n          <= '0;
      r_issued     <= '0;
      r_recvd      <= '0;
      r_beats_left <= '0;
      r_wbuf_full  <= 1'b0;
      r_dout       <= '0;
      r_dout_ready <= 1'b0;
      r_proto_err  <= 1'b0;
      r_drain      <= DRAIN_INIT;
    end else begin
      r_dout_ready <= 1'b0;
      if (w_rd_acc) begin
        r_n      <= w_n;
        r_issued <= '0;
        r_recvd  <= '0;
        if (DDRAM_WE) r_proto_err <= 1'b1;
      end
      if (w_we_acc_idle) begin
        r_wbuf_full  <= 1'b1;
        r_beats_left <= w_n - 8'd1;
      end
      if (r_state == S_RD) begin
        if (w_rd_take) r_issued <= r_issued + 8'd1;
        if (w_ret) begin
          r_recvd      <= r_recvd + 8'd1;
          r_dout       <= MEM_DOUT;
          r_dout_ready <= 1'b1;
        end
      end
      if (r_state == S_WR) begin
        if (w_wr_take) r_wbuf_full <= 1'b0;
        if (w_we_acc_wr) begin
          r_wbuf_full  <= 1'b1;
          r_beats_left <= r_beats_left - 8'd1;
        end
        if (w_rd_abort) begin
          r_proto_err  <= 1'b1;
          r_beats_left <= '0;
        end
      end
      // Returns outside a read burst: the first few after reset belong to an aborted burst
      if (MEM_DOUT_VALID && r_state != S_RD) begin
        if (r_drain != '0) r_drain <= r_drain - 1'b1;
        else               r_proto_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_rd_acc) r_start <= DDRAM_ADDR;
    if (w_we_acc_idle) begin
      r_waddr <= DDRAM_ADDR;
      r_wdata <= DDRAM_DIN;
      r_wbe   <= DDRAM_BE;
    end else if (w_we_acc_wr) begin
      r_waddr <= r_waddr + 1'b1;
      r_wdata <= DDRAM_DIN;
      r_wbe   <= DDRAM_BE;
    end
  end
endmodule

// File: tb/tb_ddram_burst_responder.sv
// Scoreboard bench for ddram_burst_responder: a master drives bursts, a memory model serves
// the MEM port, and monitors compare against a word-level reference memory.
module tb_ddram_burst_responder;
  localparam int AB   = 24;
  localparam int MAXO = 8;

  typedef struct {logic [63:0] d; bit last;} rd_t;
  typedef struct {logic [AB:0] a; logic [63:0] d; logic [7:0] be;} wr_t;
  typedef struct {logic [63:0] d; int due;} pend_t;

  logic CLK = 0, RESET = 1;
  logic [AB:0] DDRAM_ADDR = '0;
  logic [63:0] DDRAM_DIN = '0;
  logic [7:0]  DDRAM_BE = '0, DDRAM_BURSTCNT = '0;
  logic        DDRAM_RD = 0, DDRAM_WE = 0;
  logic        DDRAM_BUSY, DDRAM_DOUT_READY, MEM_RD, MEM_WE, PROTO_ERR;
  logic [63:0] DDRAM_DOUT, MEM_DIN;
  logic [AB:0] MEM_ADDR;
  logic [7:0]  MEM_BE;
  logic        MEM_WAIT = 0, MEM_DOUT_VALID = 0;
  logic [63:0] MEM_DOUT = '0;

  int compared = 0, mismatched = 0;
  int lat = 3, wait_pct = 0, force_wait = 0, inject = 0, beats_seen = 0, cyc = 0;
  rd_t         exp_rd[$];
  logic [AB:0] exp_ra[$];
  wr_t         exp_wr[$];
  pend_t       pend[$];
  logic [63:0] ref_mem [logic [AB:0]];
  logic [63:0] phys_mem [logic [AB:0]];
  logic [63:0] wd [16];
  logic [7:0]  wb [16];

  ddram_burst_responder #(.ADDRBITS(AB), .MAX_OUTSTANDING(MAXO)) dut (
    .CLK(CLK), .RESET(RESET), .DDRAM_ADDR(DDRAM_ADDR), .DDRAM_DIN(DDRAM_DIN),
    .DDRAM_BE(DDRAM_BE), .DDRAM_BURSTCNT(DDRAM_BURSTCNT), .DDRAM_RD(DDRAM_RD),
    .DDRAM_WE(DDRAM_WE), .DDRAM_BUSY(DDRAM_BUSY), .DDRAM_DOUT(DDRAM_DOUT),
    .DDRAM_DOUT_READY(DDRAM_DOUT_READY), .MEM_ADDR(MEM_ADDR), .MEM_RD(MEM_RD),
    .MEM_WE(MEM_WE), .MEM_DIN(MEM_DIN), .MEM_BE(MEM_BE), .MEM_WAIT(MEM_WAIT),
    .MEM_DOUT(MEM_DOUT), .MEM_DOUT_VALID(MEM_DOUT_VALID), .PROTO_ERR(PROTO_ERR));

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b, want %b", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] pattern(input logic [AB:0] a);
    return {7'h2A, a, 7'h15, ~a};
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                        input logic [7:0] be);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [63:0] ref_rd(input logic [AB:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : pattern(a);
  endfunction

  function automatic logic [63:0] phys_rd(input logic [AB:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : pattern(a);
  endfunction

  // Read-beat monitor
  initial begin : mon
    rd_t e;
    forever begin
      @(negedge CLK);
      if (DDRAM_DOUT_READY === 1'b1) begin
        beats_seen++;
        if (exp_rd.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL unexpected_dout_ready: got data %h, want no beat", DDRAM_DOUT);
        end else begin
          e = exp_rd.pop_front();
          chk("rd_data", DDRAM_DOUT, e.d);
          if (e.last) chk1("busy_after_last_beat", DDRAM_BUSY, 1'b0);
        end
      end
    end
  end

  // MEM-side memory model: in-order returns after 'lat' cycles, random/forced waits
  initial begin : mem
    pend_t p;
    wr_t   w;
    int    n_out;
    forever begin
      @(negedge CLK); #2;
      n_out = pend.size();
      if (force_wait > 0) begin
        MEM_WAIT = 1'b1;
        force_wait--;
      end else begin
        MEM_WAIT = (wait_pct > 0) && ($urandom_range(99) < wait_pct);
      end
      MEM_DOUT = {$urandom, $urandom};
      MEM_DOUT_VALID = 1'b0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        p = pend.pop_front();
        MEM_DOUT_VALID = 1'b1;
        MEM_DOUT = p.d;
      end else if (inject > 0) begin
        MEM_DOUT_VALID = 1'b1;
        inject--;
      end
      if (MEM_RD && !MEM_WAIT) begin
        chk1("outstanding_limit", n_out < MAXO, 1'b1);
        if (exp_ra.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL unexpected_mem_rd: got addr %h, want no read", MEM_ADDR);
        end else begin
          chk("mem_rd_addr", 64'(MEM_ADDR), 64'(exp_ra.pop_front()));
        end
        p.d = phys_rd(MEM_ADDR);
        p.due = cyc + lat;
        pend.push_back(p);
      end
      if (MEM_WE && !MEM_WAIT) begin
        if (exp_wr.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL unexpected_mem_we: got addr %h data %h, want no write", MEM_ADDR, MEM_DIN);
        end else begin
          w = exp_wr.pop_front();
          chk("mem_wr_addr", 64'(MEM_ADDR), 64'(w.a));
          chk("mem_wr_data", MEM_DIN, w.d);
          chk("mem_wr_be", 64'(MEM_BE), 64'(w.be));
        end
        phys_mem[MEM_ADDR] = merge(phys_rd(MEM_ADDR), MEM_DIN, MEM_BE);
      end
      cyc++;
    end
  end

  task automatic step();
    @(negedge CLK); #1;
  endtask

  task automatic wait_accept(input string nm);
    bit acc;
    int k;
    acc = 0;
    for (k = 0; k < 500 && !acc; k++) begin
      #2;
      acc = !DDRAM_BUSY;
      step();
    end
    compared++;
    if (!acc) begin
      mismatched++;
      $display("FAIL %s: got BUSY stuck high for %0d cycles, want accept", nm, k);
    end
  endtask

  task automatic wait_empty(input string nm);
    int k;
    k = 0;
    while ((exp_rd.size() != 0 || exp_wr.size() != 0 || exp_ra.size() != 0 || pend.size() != 0)
           && k < 3000) begin
      step();
      k++;
    end
    compared++;
    if (k >= 3000) begin
      mismatched++;
      $display("FAIL %s: got rd %0d wr %0d beats pending after timeout, want 0",
               nm, exp_rd.size(), exp_wr.size());
    end
    step();
  endtask

  task automatic do_reset(input int cycles);
    RESET = 1; DDRAM_RD = 0; DDRAM_WE = 0;
    exp_rd.delete(); exp_ra.delete(); exp_wr.delete();
    for (int k = 0; k < cycles; k++) begin
      #2;
      chk1("busy_in_reset", DDRAM_BUSY, 1'b1);
      step();
    end
    RESET = 0;
  endtask

  task automatic send_rd(input logic [AB:0] addr, input logic [7:0] cnt, input bit with_we);
    int  n;
    rd_t e;
    logic [AB:0] a;
    n = (cnt == 0) ? 1 : int'(cnt);
    for (int i = 0; i < n; i++) begin
      a = addr + (AB+1)'(i);
      exp_ra.push_back(a);
      e.d = ref_rd(a);
      e.last = (i == n - 1);
      exp_rd.push_back(e);
    end
    DDRAM_ADDR = addr; DDRAM_BURSTCNT = cnt; DDRAM_DIN = {$urandom, $urandom};
    DDRAM_BE = 8'($urandom); DDRAM_RD = 1; DDRAM_WE = with_we;
    wait_accept("rd_accept");
    DDRAM_RD = 0; DDRAM_WE = 0; DDRAM_ADDR = (AB+1)'($urandom);
  endtask

  task automatic send_wr(input logic [AB:0] addr, input logic [7:0] cnt, input int nsend);
    wr_t w;
    logic [AB:0] a;
    a = addr;
    for (int i = 0; i < nsend; i++) begin
      w.a = a; w.d = wd[i]; w.be = wb[i];
      exp_wr.push_back(w);
      ref_mem[a] = merge(ref_rd(a), wd[i], wb[i]);
      DDRAM_ADDR = (i == 0) ? addr : (AB+1)'($urandom);
      DDRAM_BURSTCNT = (i == 0) ? cnt : 8'($urandom);
      DDRAM_DIN = wd[i]; DDRAM_BE = wb[i]; DDRAM_WE = 1;
      wait_accept("wr_accept");
      DDRAM_WE = 0;
      a = a + 1'b1;
    end
  endtask

  initial begin : master
    int n, base;
    logic [AB:0] addr;
    logic [7:0]  cnt;
    step();
    do_reset(2);
    #2;
    chk1("reset_busy_low", DDRAM_BUSY, 1'b0);
    chk1("reset_proto_err", PROTO_ERR, 1'b0);
    chk1("reset_dout_ready", DDRAM_DOUT_READY, 1'b0);
    chk1("reset_mem_rd", MEM_RD, 1'b0);
    chk1("reset_mem_we", MEM_WE, 1'b0);
    chk("reset_dout", DDRAM_DOUT, 64'd0);
    chk("reset_mem_addr", 64'(MEM_ADDR), 64'd0);
    step();

    // Returns with nothing outstanding: first MAXO after reset are silent, the next one flags
    inject = MAXO;
    for (int k = 0; k < MAXO + 4; k++) step();
    chk1("drain_silent", PROTO_ERR, 1'b0);
    inject = 1;
    for (int k = 0; k < 4; k++) step();
    chk1("stray_return_flag", PROTO_ERR, 1'b1);
    do_reset(1);
    step();

    lat = 3; wait_pct = 0;
    send_rd(25'h100, 8'd8, 0);
    wait_empty("rd_0x100");

    lat = 20;
    send_rd(25'h400, 8'd16, 0);
    wait_empty("rd_lat20");

    lat = 3;
    wd[0] = 64'hAABBCCDDEEFF0011; wb[0] = 8'h0F;
    force_wait = 6;
    send_wr(25'h2000, 8'd1, 1);
    for (int k = 0; k < 3; k++) begin
      #2;
      chk1("busy_held_mem_wait", DDRAM_BUSY, 1'b1);
      step();
    end
    wait_empty("wr_0x2000");
    send_rd(25'h2000, 8'd1, 0);
    wait_empty("rd_0x2000");

    for (int i = 0; i < 4; i++) begin
      wd[i] = {$urandom, $urandom};
      wb[i] = 8'($urandom);
    end
    wait_pct = 30;
    send_wr(25'h1FFFFFF, 8'd4, 4);
    wait_empty("wr_wrap");
    send_rd(25'h1FFFFFF, 8'd4, 0);
    wait_empty("rd_wrap");
    wait_pct = 0;

    send_rd(25'h2000, 8'd2, 1);
    wait_empty("rd_we_same_cycle");
    chk1("proto_rd_we", PROTO_ERR, 1'b1);
    send_rd(25'h10, 8'd0, 0);
    wait_empty("rd_cnt0");
    chk1("proto_sticky", PROTO_ERR, 1'b1);
    do_reset(1);
    #2;
    chk1("proto_cleared", PROTO_ERR, 1'b0);
    step();

    // Read arriving while a write burst awaits its next beat
    wd[0] = 64'h1122334455667788; wb[0] = 8'hFF;
    send_wr(25'h500, 8'd3, 1);
    wait_empty("wr_partial");
    #2;
    chk1("busy_low_wr_wait", DDRAM_BUSY, 1'b0);
    step();
    DDRAM_ADDR = 25'h600; DDRAM_BURSTCNT = 8'd1; DDRAM_RD = 1;
    step();
    DDRAM_RD = 0;
    step();
    #2;
    chk1("proto_wr_abort", PROTO_ERR, 1'b1);
    chk1("idle_after_abort", DDRAM_BUSY, 1'b0);
    step();
    send_rd(25'h500, 8'd3, 0);
    wait_empty("rd_after_abort");
    do_reset(1);
    step();

    lat = 4;
    base = beats_seen;
    send_rd(25'h300, 8'd8, 0);
    for (int k = 0; k < 300 && beats_seen < base + 3; k++) step();
    chk1("three_beats_before_reset", beats_seen >= base + 3, 1'b1);
    do_reset(1);
    for (int k = 0; k < 100 && pend.size() > 0; k++) step();
    for (int k = 0; k < 3; k++) step();
    chk1("late_data_silent", PROTO_ERR, 1'b0);
    send_rd(25'h300, 8'd8, 0);
    wait_empty("rd_after_reset");

    for (int it = 0; it < 30; it++) begin
      lat = $urandom_range(1, 6);
      wait_pct = ($urandom_range(1) == 1) ? 30 : 0;
      addr = ($urandom_range(3) == 0) ? 25'h1FFFFF8 + 25'($urandom_range(7))
                                      : 25'($urandom_range(40));
      cnt = 8'($urandom_range(10));
      if ($urandom_range(1) == 1) begin
        n = (cnt == 0) ? 1 : int'(cnt);
        for (int i = 0; i < n; i++) begin
          wd[i] = {$urandom, $urandom};
          wb[i] = 8'($urandom);
        end
        send_wr(addr, cnt, n);
      end else begin
        send_rd(addr, cnt, 0);
      end
    end
    wait_empty("random_drain");
    chk1("proto_clean_random", PROTO_ERR, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
